// File: rtl/seq_serializer.sv
// Parallel-to-serial feeder for the Moore sequence detector: takes WIDTH-bit words
// over valid/ready and shifts them out one bit per clock, with a 1-entry hold for gapless streams.
module seq_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shifter;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [CNT_W-1:0] r_bit_cnt;

    logic             w_accept;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_shifted;

    // The hold register is the only back-pressure source, so readiness is just "hold is empty".
    assign w_accept   = din_valid & ~r_hold_full;
    assign w_last_bit = (r_state == ST_SHIFT) && (r_bit_cnt == CNT_W'(WIDTH - 1));
    assign w_shifted  = MSB_FIRST ? {r_shifter[WIDTH-2:0], 1'b0}
                                  : {1'b0, r_shifter[WIDTH-1:1]};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the default assignment up front keeps this block from inferring a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_last_bit && !r_hold_full && !w_accept) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // On the last-bit edge the held word wins over a bypass; a bypass never touches hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shifter   <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_bit_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_shifter <= din;
                        r_bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_last_bit) begin
                        r_bit_cnt <= '0;
                        if (r_hold_full) begin
                            r_shifter   <= r_hold;
                            r_hold_full <= 1'b0;
                        end else if (w_accept) begin
                            r_shifter <= din;
                        end else begin
                            r_shifter <= '0;
                        end
                    end else begin
                        r_shifter <= w_shifted;
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        if (w_accept) begin
                            r_hold      <= din;
                            r_hold_full <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_shifter   <= '0;
                    r_hold_full <= 1'b0;
                    r_bit_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (r_state == ST_SHIFT);
        out       = out_valid & (MSB_FIRST ? r_shifter[WIDTH-1] : r_shifter[0]);
        busy      = out_valid | r_hold_full;
        din_ready = ~r_hold_full;
    end

    // A held word only exists while a word is being shifted; otherwise it would be stranded.
    hold_implies_shift: assert property (
        @(posedge clk) disable iff (!rst) r_hold_full |-> (r_state == ST_SHIFT)
    );

endmodule

// File: tb/tb_seq_serializer.sv
// Directed bench for seq_serializer: MSB-first and LSB-first 8-bit instances plus a
// 2-bit instance, each bit checked on the falling edge against hand-computed streams.
module tb_seq_serializer;

    logic       clk = 1'b0;
    logic       rst;

    logic [7:0] d0, d1;
    logic [1:0] d2;
    logic       v0, v1, v2;
    logic       rdy0, rdy1, rdy2;
    logic       out0, out1, out2;
    logic       ov0, ov1, ov2;
    logic       busy0, busy1, busy2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .din(d0), .din_valid(v0), .din_ready(rdy0),
        .out(out0), .out_valid(ov0), .busy(busy0)
    );

    seq_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .din(d1), .din_valid(v1), .din_ready(rdy1),
        .out(out1), .out_valid(ov1), .busy(busy1)
    );

    seq_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_w2 (
        .clk(clk), .rst(rst), .din(d2), .din_valid(v2), .din_ready(rdy2),
        .out(out2), .out_valid(ov2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [7:0]  w;
        logic [23:0] s;

        rst = 1'b0;
        d0 = '0; d1 = '0; d2 = '0;
        v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;

        // Reset state
        #2;
        check("rst_out",   out0,  1'b0);
        check("rst_ov",    ov0,   1'b0);
        check("rst_busy",  busy0, 1'b0);
        check("rst_ready", rdy0,  1'b1);
        check("rst_ov_w2", ov2,   1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // T1: single word MSB first from IDLE
        w = 8'b0101_0111;
        @(negedge clk);
        d0 = w; v0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t1_bit%0d", k), out0, w[7-k]);
            check($sformatf("t1_ov%0d", k),  ov0,  1'b1);
            if (k == 0) v0 = 1'b0;
            if (k == 3) check("t1_busy", busy0, 1'b1);
        end
        @(negedge clk);
        check("t1_idle_ov",   ov0,   1'b0);
        check("t1_idle_out",  out0,  1'b0);
        check("t1_idle_busy", busy0, 1'b0);

        // T2 + T3: back-to-back words and a third word under back-pressure
        s = {8'hA5, 8'h3C, 8'hFF};
        @(negedge clk);
        d0 = 8'hA5; v0 = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            check($sformatf("t23_bit%0d", c),   out0, s[24-c]);
            check($sformatf("t23_ov%0d", c),    ov0,  1'b1);
            check($sformatf("t23_ready%0d", c), rdy0, (c == 1) || (c == 9) || (c >= 17));
            if (c == 1)  d0 = 8'h3C;
            if (c == 2)  d0 = 8'hFF;
            if (c == 10) v0 = 1'b0;
        end
        @(negedge clk);
        check("t23_idle_ov",   ov0,   1'b0);
        check("t23_idle_busy", busy0, 1'b0);

        // T4: LSB-first instance
        w = 8'b0000_0110;
        @(negedge clk);
        d1 = w; v1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t4_bit%0d", k), out1, w[k]);
            check($sformatf("t4_ov%0d", k),  ov1,  1'b1);
            if (k == 0) v1 = 1'b0;
        end
        @(negedge clk);
        check("t4_idle_ov", ov1, 1'b0);

        // T5: reset mid-word with hold full
        w = 8'hA5;
        @(negedge clk);
        d0 = w; v0 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("t5_pre_bit%0d", k), out0, w[7-k]);
            if (k == 0) d0 = 8'h3C;
            if (k == 1) v0 = 1'b0;
        end
        check("t5_pre_ready", rdy0, 1'b0);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_out",   out0,  1'b0);
        check("t5_rst_ov",    ov0,   1'b0);
        check("t5_rst_busy",  busy0, 1'b0);
        check("t5_rst_ready", rdy0,  1'b1);
        d0 = 8'hFF; v0 = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_in_rst_ov", ov0, 1'b0);
        v0 = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_post_ov",   ov0,   1'b0);
        check("t5_post_busy", busy0, 1'b0);
        w = 8'hC3;
        d0 = w; v0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("t5_bit%0d", k), out0, w[7-k]);
            check($sformatf("t5_ov%0d", k),  ov0,  1'b1);
            if (k == 0) v0 = 1'b0;
        end
        @(negedge clk);
        check("t5_idle_ov",   ov0,   1'b0);
        check("t5_idle_busy", busy0, 1'b0);

        // T6a: WIDTH=2 bypass on the last-bit edge
        @(negedge clk);
        d2 = 2'b10; v2 = 1'b1;
        @(negedge clk);
        check("t6a_c1_out", out2, 1'b1);
        check("t6a_c1_ov",  ov2,  1'b1);
        v2 = 1'b0;
        @(negedge clk);
        check("t6a_c2_out",   out2, 1'b0);
        check("t6a_c2_ready", rdy2, 1'b1);
        d2 = 2'b01; v2 = 1'b1;
        @(negedge clk);
        check("t6a_c3_out",   out2, 1'b0);
        check("t6a_c3_ov",    ov2,  1'b1);
        check("t6a_c3_ready", rdy2, 1'b1);
        v2 = 1'b0;
        @(negedge clk);
        check("t6a_c4_out", out2, 1'b1);
        @(negedge clk);
        check("t6a_c5_ov", ov2, 1'b0);

        // T6b: WIDTH=2 with din_valid held high, continuous 1,0 stream
        @(negedge clk);
        d2 = 2'b10; v2 = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            check($sformatf("t6b_bit%0d", c), out2, (c % 2) == 1);
            check($sformatf("t6b_ov%0d", c),  ov2,  1'b1);
            if (c == 8) v2 = 1'b0;
        end
        @(negedge clk);
        check("t6b_idle_ov",   ov2,   1'b0);
        check("t6b_idle_busy", busy2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
